// File: rtl/snow64_instr_fetch.sv
// rtl/snow64_instr_fetch.sv - Single-outstanding instruction fetch unit with redirect handling and decode FIFO
// Optional perf counters enabled by defining SNOW64_INSTR_FETCH_PERF_COUNTERS_EN.

module snow64_instr_fetch #(
  parameter int                         WIDTH__CPU_ADDR = 64,
  parameter int                         WIDTH__INSTR    = 32,
  parameter int                         DEPTH__FIFO     = 4,
  parameter logic [WIDTH__CPU_ADDR-1:0] RESET_PC        = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_redirect_valid,
  input  logic [WIDTH__CPU_ADDR-1:0] in_redirect_addr,
  output logic                       out_req_read_req,
  output logic [WIDTH__CPU_ADDR-1:0] out_req_read_addr,
  input  logic                       in_req_read_valid,
  input  logic [WIDTH__INSTR-1:0]    in_req_read_instr,
  output logic                       out_decode_valid,
  output logic [WIDTH__INSTR-1:0]    out_decode_instr,
  output logic [WIDTH__CPU_ADDR-1:0] out_decode_pc,
  input  logic                       in_decode_ready
`ifdef SNOW64_INSTR_FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]                out_perf_fetched,
  output logic [31:0]                out_perf_discarded
`endif
);

  localparam int PTR_W = (DEPTH__FIFO > 1) ? $clog2(DEPTH__FIFO) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(DEPTH__FIFO);

  typedef enum logic [1:0] {
    StIdle         = 2'd0,
    StWaitForCache = 2'd1,
    StDiscard      = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [WIDTH__CPU_ADDR-1:0] fetch_pc_q, fetch_pc_d;
  logic                       req_q, req_d;
  logic [WIDTH__CPU_ADDR-1:0] req_addr_q, req_addr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;

  logic [WIDTH__INSTR-1:0]    fifo_instr_q [DEPTH__FIFO];
  logic [WIDTH__CPU_ADDR-1:0] fifo_pc_q    [DEPTH__FIFO];

  logic                       push;
  logic                       pop;
  logic [WIDTH__CPU_ADDR-1:0] redirect_pc;

  assign redirect_pc = in_redirect_addr & ~WIDTH__CPU_ADDR'(3);

  // A redirect flushes the FIFO, so it also suppresses any same-cycle pop.
  assign pop = (count_q != '0) && in_decode_ready && !in_redirect_valid;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = 1'b0;
    req_addr_d = req_addr_q;
    push       = 1'b0;

    case (state_q)
      StIdle: begin
        if (in_redirect_valid) begin
          fetch_pc_d = redirect_pc;
        end else if (count_q != FIFO_FULL) begin
          req_d      = 1'b1;
          req_addr_d = fetch_pc_q;
          state_d    = StWaitForCache;
        end
      end

      StWaitForCache: begin
        if (in_redirect_valid) begin
          fetch_pc_d = redirect_pc;
          state_d    = in_req_read_valid ? StIdle : StDiscard;
        end else if (in_req_read_valid) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + WIDTH__CPU_ADDR'(4);
          state_d    = StIdle;
        end
      end

      StDiscard: begin
        // The stale response still terminates the outstanding request.
        if (in_redirect_valid) begin
          fetch_pc_d = redirect_pc;
        end
        if (in_req_read_valid) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (in_redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      req_addr_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      req_addr_q <= req_addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: count_q gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= in_req_read_instr;
      fifo_pc_q[wr_ptr_q]    <= fetch_pc_q;
    end
  end

  assign out_req_read_req  = req_q;
  assign out_req_read_addr = req_addr_q;
  assign out_decode_valid  = (count_q != '0);
  assign out_decode_instr  = fifo_instr_q[rd_ptr_q];
  assign out_decode_pc     = fifo_pc_q[rd_ptr_q];

`ifdef SNOW64_INSTR_FETCH_PERF_COUNTERS_EN
  logic        drop;
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_discarded_q;

  assign drop = in_req_read_valid &&
                ((state_q == StDiscard) ||
                 ((state_q == StWaitForCache) && in_redirect_valid));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q   <= '0;
      perf_discarded_q <= '0;
    end else begin
      if (push && (perf_fetched_q != '1)) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (drop && (perf_discarded_q != '1)) begin
        perf_discarded_q <= perf_discarded_q + 32'd1;
      end
    end
  end

  assign out_perf_fetched   = perf_fetched_q;
  assign out_perf_discarded = perf_discarded_q;
`endif

endmodule

// File: tb/tb_snow64_instr_fetch.sv
// tb/tb_snow64_instr_fetch.sv - Scoreboard bench for snow64_instr_fetch against a queue-based fetch model
module tb_snow64_instr_fetch;

  localparam int          AW     = 64;
  localparam int          IW     = 32;
  localparam int          DEPTH  = 4;
  localparam logic [63:0] RST_PC = 64'h0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_redirect_valid = 1'b0;
  logic [AW-1:0] in_redirect_addr = '0;
  logic          out_req_read_req;
  logic [AW-1:0] out_req_read_addr;
  logic          in_req_read_valid = 1'b0;
  logic [IW-1:0] in_req_read_instr = '0;
  logic          out_decode_valid;
  logic [IW-1:0] out_decode_instr;
  logic [AW-1:0] out_decode_pc;
  logic          in_decode_ready = 1'b0;

  snow64_instr_fetch #(
    .WIDTH__CPU_ADDR(AW),
    .WIDTH__INSTR(IW),
    .DEPTH__FIFO(DEPTH),
    .RESET_PC(RST_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_redirect_valid(in_redirect_valid),
    .in_redirect_addr(in_redirect_addr),
    .out_req_read_req(out_req_read_req),
    .out_req_read_addr(out_req_read_addr),
    .in_req_read_valid(in_req_read_valid),
    .in_req_read_instr(in_req_read_instr),
    .out_decode_valid(out_decode_valid),
    .out_decode_instr(out_decode_instr),
    .out_decode_pc(out_decode_pc),
    .in_decode_ready(in_decode_ready)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Reference model: architectural fetch PC, expected decode queue, one outstanding request.
  logic [63:0] m_pc = RST_PC;
  ent_t        m_q[$];
  bit          m_out = 1'b0;
  bit          m_stale = 1'b0;
  int          m_pushes = 0;

  int n_vec = 0;
  int n_miss = 0;

  // Stimulus / cache-responder controls.
  bit pend = 1'b0;
  int pend_cnt = 0;
  int delay_fix = 2;
  bit delay_rnd = 1'b0;
  bit spur_en = 1'b0;
  bit redir_rnd = 1'b0;
  int rdy_mode = 1;
  bit req_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_pc = RST_PC;
      m_q.delete();
      m_out = 1'b0;
      m_stale = 1'b0;
    end else begin
      if (in_redirect_valid && m_out) m_stale = 1'b1;
      if (in_decode_ready && !in_redirect_valid && m_q.size() != 0) void'(m_q.pop_front());
      if (in_req_read_valid && m_out) begin
        if (!m_stale) begin
          ent_t e;
          e.pc = m_pc;
          e.instr = in_req_read_instr;
          m_q.push_back(e);
          m_pc = m_pc + 64'd4;
          m_pushes++;
        end
        m_out = 1'b0;
        m_stale = 1'b0;
      end
      if (in_redirect_valid) begin
        m_q.delete();
        m_pc = {in_redirect_addr[63:2], 2'b00};
      end
    end
  end

  // Monitor: compares the FIFO head and every issued request against the model.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("decode_valid", {63'd0, out_decode_valid}, {63'd0, m_q.size() != 0});
      if (m_q.size() != 0) begin
        chk("decode_pc", out_decode_pc, m_q[0].pc);
        chk("decode_instr", {32'd0, out_decode_instr}, {32'd0, m_q[0].instr});
      end
      if (out_req_read_req) begin
        chk("req_one_outstanding", {63'd0, m_out}, 64'd0);
        chk("req_addr", out_req_read_addr, m_pc);
        chk("req_fifo_room", {63'd0, m_q.size() < DEPTH}, 64'd1);
        m_out = 1'b1;
        m_stale = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
    req_seen = out_req_read_req;
    in_redirect_valid = 1'b0;
    in_req_read_valid = 1'b0;
    if (!rst) begin
      case (rdy_mode)
        0:       in_decode_ready = 1'b0;
        1:       in_decode_ready = 1'b1;
        default: in_decode_ready = 1'($urandom_range(1));
      endcase
      if (pend) begin
        if (pend_cnt == 0) begin
          in_req_read_valid = 1'b1;
          in_req_read_instr = $urandom;
          pend = 1'b0;
        end else begin
          pend_cnt--;
        end
      end else if (out_req_read_req) begin
        pend = 1'b1;
        pend_cnt = (delay_rnd ? $urandom_range(4, 1) : delay_fix) - 1;
      end else if (spur_en && $urandom_range(9) == 0) begin
        in_req_read_valid = 1'b1;
        in_req_read_instr = $urandom;
      end
      if (redir_rnd && $urandom_range(19) == 0) begin
        in_redirect_valid = 1'b1;
        if ($urandom_range(3) == 0) in_redirect_addr = {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom)};
        else                         in_redirect_addr = {$urandom, $urandom};
      end
    end
  endtask

  task automatic wait_req(input string name, output logic [63:0] addr, output int n);
    req_seen = 1'b0;
    n = 0;
    for (int i = 0; i < 50 && !req_seen; i++) begin
      tick();
      n++;
    end
    chk({name, "_seen"}, {63'd0, req_seen}, 64'd1);
    addr = out_req_read_addr;
  endtask

  // Called at negedge+2: asserts reset off-edge, checks outputs clear immediately.
  task automatic do_reset();
    #1;
    rst = 1'b1;
    pend = 1'b0;
    in_req_read_valid = 1'b0;
    in_redirect_valid = 1'b0;
    in_decode_ready = 1'b0;
    #1;
    chk("rst_decode_valid", {63'd0, out_decode_valid}, 64'd0);
    chk("rst_req", {63'd0, out_req_read_req}, 64'd0);
    chk("rst_req_addr", out_req_read_addr, 64'd0);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    int n;
    int nreq;

    tick();
    do_reset();

    // Back-to-back fetches, response 2 cycles after each request.
    rdy_mode = 1;
    delay_fix = 2;
    for (int k = 0; k < 4; k++) begin
      wait_req("seq", a, n);
      chk("seq_addr", a, 64'(k * 4));
    end

    // Decode stalled: FIFO fills, then one pop frees one request slot.
    do_reset();
    rdy_mode = 0;
    delay_fix = 1;
    nreq = 0;
    repeat (40) begin
      tick();
      if (req_seen) nreq++;
    end
    chk("full_req_count", 64'(nreq), 64'd4);
    chk("full_valid", {63'd0, out_decode_valid}, 64'd1);
    tick();
    in_decode_ready = 1'b1;
    wait_req("after_pop", a, n);
    chk("after_pop_addr", a, 64'h10);
    nreq = 0;
    repeat (20) begin
      tick();
      if (req_seen) nreq++;
    end
    chk("refull_no_req", 64'(nreq), 64'd0);

    // Redirect while waiting, response one cycle later is dropped.
    do_reset();
    rdy_mode = 0;
    delay_fix = 2;
    wait_req("wait_redir_first", a, n);
    tick();
    in_redirect_valid = 1'b1;
    in_redirect_addr = 64'h1003;
    tick();
    tick();
    chk("wait_redir_empty", {63'd0, out_decode_valid}, 64'd0);
    wait_req("wait_redir_next", a, n);
    chk("wait_redir_addr", a, 64'h1000);

    // Redirect coincident with the response.
    do_reset();
    rdy_mode = 0;
    delay_fix = 1;
    wait_req("same_redir_first", a, n);
    tick();
    in_redirect_valid = 1'b1;
    in_redirect_addr = 64'h2000;
    wait_req("same_redir_next", a, n);
    chk("same_redir_addr", a, 64'h2000);
    chk("same_redir_idle_latency", 64'(n), 64'd2);
    chk("same_redir_not_pushed", {63'd0, out_decode_valid}, 64'd0);

    // Fetch PC wraps past the top of the address space.
    do_reset();
    rdy_mode = 0;
    delay_fix = 1;
    tick();
    in_redirect_valid = 1'b1;
    in_redirect_addr = 64'hFFFF_FFFF_FFFF_FFFE;
    wait_req("wrap_first", a, n);
    chk("wrap_first_addr", a, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_req("wrap_next", a, n);
    chk("wrap_next_addr", a, 64'h0);
    chk("wrap_head_pc", out_decode_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // Asynchronous reset mid-wait with three buffered entries.
    do_reset();
    rdy_mode = 0;
    delay_fix = 1;
    for (int k = 0; k < 3; k++) wait_req("fill", a, n);
    delay_fix = 4;
    wait_req("fill_last", a, n);
    chk("pre_rst_valid", {63'd0, out_decode_valid}, 64'd1);
    chk("pre_rst_addr", a, 64'hC);
    do_reset();
    wait_req("post_rst", a, n);
    chk("post_rst_addr", a, RST_PC);

    // Randomized traffic against the model.
    rdy_mode = 2;
    delay_rnd = 1'b1;
    spur_en = 1'b1;
    redir_rnd = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (i == 2000) do_reset();
    end
    redir_rnd = 1'b0;
    spur_en = 1'b0;
    rdy_mode = 1;
    repeat (20) tick();
    chk("random_progress", {63'd0, m_pushes > 300}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
